// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter
//   Two-requester valid/ready arbiter feeding a single registered output slot.
//   The slot holds one word. It can be drained and refilled in the same cycle,
//   which gives one word per cycle. When both requesters are valid, the
//   requester that was not served by the last accepted transfer wins
//   (round-robin).
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   d1/v1/r1    requester 1 data / valid / ready
//   d2/v2/r2    requester 2 data / valid / ready
//   q           registered output data
//   q_valid     output slot holds a word
//   q_ready     downstream ready
//   sel         source of the word in q (0 = d1, 1 = d2)
//   xfer_count  number of completed output transfers (wraps at 16 bits)
module mux2_stream_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d1,
    input  logic             v1,
    output logic             r1,
    input  logic [WIDTH-1:0] d2,
    input  logic             v2,
    output logic             r2,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             sel,
    output logic [15:0]      xfer_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_p0;
    state_t           state_nxt;
    logic             last_p0;      // 0: requester 1 served last, 1: requester 2
    logic             grant2;       // 1 when requester 2 holds the grant
    logic             can_accept;
    logic             out_xfer;
    logic [WIDTH-1:0] q_p0;
    logic             sel_p0;
    logic [15:0]      cnt_p0;

    // Grant and ready are combinational on valids, q_ready, state and last only;
    // the data inputs never reach the ready path.
    always_comb begin
        state_nxt  = state_p0;
        grant2     = 1'b0;
        can_accept = (state_p0 == EMPTY) || q_ready;
        out_xfer   = (state_p0 == FULL) && q_ready;
        r1         = 1'b0;
        r2         = 1'b0;

        if (v1 && v2) begin
            grant2 = ~last_p0;
        end else begin
            grant2 = v2;
        end

        if (!rst) begin
            r1 = can_accept && v1 && !grant2;
            r2 = can_accept && v2 && grant2;
        end

        if (r1 || r2) begin
            state_nxt = FULL;
        end else if (out_xfer) begin
            state_nxt = EMPTY;
        end
    end

    // Stage p0: output slot, round-robin pointer and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= EMPTY;
            q_p0     <= '0;
            sel_p0   <= 1'b0;
            last_p0  <= 1'b1;   // requester 1 wins the first tie
            cnt_p0   <= 16'h0000;
        end else begin
            state_p0 <= state_nxt;
            if (r1 || r2) begin
                q_p0    <= r2 ? d2 : d1;
                sel_p0  <= r2;
                last_p0 <= r2;
            end
            if (out_xfer) begin
                cnt_p0 <= cnt_p0 + 16'd1;
            end
        end
    end

    assign q          = q_p0;
    assign sel        = sel_p0;
    assign q_valid    = (state_p0 == FULL);
    assign xfer_count = cnt_p0;

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
module tb_mux2_stream_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d1, d2;
    logic             v1, v2;
    logic             r1, r2;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic             sel;
    logic [15:0]      xfer_count;

    int compared   = 0;
    int mismatched = 0;

    // expected {sel, q} of each word leaving the output slot
    logic [WIDTH:0] sb_q[$];

    mux2_stream_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .d1         (d1),
        .v1         (v1),
        .r1         (r1),
        .d2         (d2),
        .v2         (v2),
        .r2         (r2),
        .q          (q),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .sel        (sel),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s, input logic [WIDTH-1:0] d);
        sb_q.push_back({s, d});
    endtask

    // Monitor: every output handshake pops one expected word
    always @(negedge clk) begin
        if (!rst && q_valid && q_ready) begin
            logic [WIDTH:0] e;
            compared++;
            if (sb_q.size() == 0) begin
                mismatched++;
                $display("FAIL out_word: got sel=%0d q=%0h expected no word", sel, q);
            end else begin
                e = sb_q.pop_front();
                if ({sel, q} !== e) begin
                    mismatched++;
                    $display("FAIL out_word: got sel=%0d q=%0h expected sel=%0d q=%0h",
                             sel, q, e[WIDTH], e[WIDTH-1:0]);
                end
            end
        end
    end

    logic [WIDTH-1:0] alt_d[4];
    logic             alt_s[4];

    initial begin
        rst = 1'b1; v1 = 1'b0; v2 = 1'b0; d1 = '0; d2 = '0; q_ready = 1'b0;
        step();
        step();
        // reset state; readies must stay low while reset is held
        chk("rst_q_valid", q_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_sel", sel, 0);
        chk("rst_count", xfer_count, 0);
        v1 = 1'b1; v2 = 1'b1; q_ready = 1'b1;
        #1;
        chk("rst_r1", r1, 0);
        chk("rst_r2", r2, 0);

        // both valid: alternate A1,B2,A1,B2 starting with requester 1
        rst = 1'b0; d1 = 8'hA1; d2 = 8'hB2;
        alt_d[0] = 8'hA1; alt_d[1] = 8'hB2; alt_d[2] = 8'hA1; alt_d[3] = 8'hB2;
        alt_s[0] = 1'b0;  alt_s[1] = 1'b1;  alt_s[2] = 1'b0;  alt_s[3] = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("alt_r1", r1, !alt_s[i]);
            chk("alt_r2", r2, alt_s[i]);
            push(alt_s[i], alt_d[i]);
            step();
            chk("alt_q", q, alt_d[i]);
            chk("alt_sel", sel, alt_s[i]);
        end
        v1 = 1'b0; v2 = 1'b0;
        step();
        chk("alt_count", xfer_count, 4);
        chk("drain_empty", q_valid, 0);
        chk("drain_q_hold", q, 8'hB2);
        chk("drain_sel_hold", sel, 1);

        // stall: word accepted once, then held while q_ready=0
        v1 = 1'b1; d1 = 8'h11; q_ready = 1'b0;
        #1;
        chk("stall_r1_first", r1, 1);
        push(1'b0, 8'h11);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_r1", r1, 0);
            chk("stall_q", q, 8'h11);
            chk("stall_valid", q_valid, 1);
            step();
        end
        v1 = 1'b0; q_ready = 1'b1;
        step();
        chk("stall_count", xfer_count, 5);
        chk("stall_empty", q_valid, 0);

        // only requester 2 for three cycles, then a tie goes to requester 1
        v2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d2 = 8'h21 + 8'(i);
            #1;
            chk("v2only_r2", r2, 1);
            chk("v2only_r1", r1, 0);
            push(1'b1, 8'h21 + 8'(i));
            step();
            chk("v2only_sel", sel, 1);
        end
        v1 = 1'b1; d1 = 8'h31; d2 = 8'h24;
        #1;
        chk("tie_r1", r1, 1);
        chk("tie_r2", r2, 0);
        push(1'b0, 8'h31);
        step();
        v1 = 1'b0; v2 = 1'b0;
        step();
        chk("v2only_count", xfer_count, 9);

        // a valid withdrawn without handshake must not move the pointer
        q_ready = 1'b0; v2 = 1'b1; d2 = 8'h41;
        push(1'b1, 8'h41);
        step();
        v2 = 1'b0; v1 = 1'b1; d1 = 8'h99;
        step();
        chk("withdraw_q", q, 8'h41);
        v1 = 1'b0;
        step();
        v1 = 1'b1; v2 = 1'b1; d1 = 8'h51; d2 = 8'h52; q_ready = 1'b1;
        #1;
        chk("withdraw_r1", r1, 1);
        push(1'b0, 8'h51);
        step();
        v1 = 1'b0; v2 = 1'b0;
        step();
        chk("withdraw_count", xfer_count, 11);

        // reset while FULL discards the held word
        q_ready = 1'b0; v1 = 1'b1; d1 = 8'h5A;
        step();
        chk("pre_rst_q", q, 8'h5A);
        chk("pre_rst_valid", q_valid, 1);
        rst = 1'b1; q_ready = 1'b1;
        #1;
        chk("mid_rst_r1", r1, 0);
        chk("mid_rst_r2", r2, 0);
        step();
        rst = 1'b0; v1 = 1'b0;
        chk("post_rst_valid", q_valid, 0);
        chk("post_rst_q", q, 0);
        chk("post_rst_count", xfer_count, 0);

        // counter wrap: 65535 transfers, then one more
        v1 = 1'b1; d1 = 8'h33; q_ready = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            push(1'b0, 8'h33);
            step();
        end
        v1 = 1'b0;
        step();
        chk("count_ffff", xfer_count, 16'hFFFF);
        v1 = 1'b1; d1 = 8'h77;
        push(1'b0, 8'h77);
        step();
        v1 = 1'b0;
        step();
        chk("count_wrap", xfer_count, 16'h0000);

        // every expected word must have left the slot
        step();
        chk("sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
